// File: rtl/uart_tx_pkg.sv
// Shared constants and types for the memory-mapped UART transmitter.
package uart_tx_pkg;

    // Register byte offsets, compared against {addr[9:2], 2'b00}
    localparam logic [9:0] UART_TXDATA = 10'h000;
    localparam logic [9:0] UART_STATUS = 10'h004;
    localparam logic [9:0] UART_DIV    = 10'h008;
    localparam logic [9:0] UART_CTRL   = 10'h00C;

    // Serialiser states
    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } uart_tx_state_e;

    // STATUS register bit positions
    localparam int unsigned STATUS_FULL_BIT  = 0;
    localparam int unsigned STATUS_EMPTY_BIT = 1;
    localparam int unsigned STATUS_BUSY_BIT  = 2;
    localparam int unsigned STATUS_LEVEL_LSB = 7;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous first-word fall-through FIFO. Pointers carry one extra wrap
// bit so that full and empty can be told apart without a separate counter.
module uart_tx_fifo #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 8,
    localparam int unsigned PtrW = $clog2(Depth)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [Width-1:0] wdata_i,
    input  logic             pop_i,
    output logic [Width-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [PtrW:0]    level_o
);

    localparam logic [PtrW:0] PtrOne = {{PtrW{1'b0}}, 1'b1};

    logic [PtrW:0]    wr_ptr_r;
    logic [PtrW:0]    rd_ptr_r;
    logic [Width-1:0] mem_r [Depth];
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full_o    = (wr_ptr_r[PtrW] != rd_ptr_r[PtrW]) &&
                       (wr_ptr_r[PtrW-1:0] == rd_ptr_r[PtrW-1:0]);
    assign empty_o   = (wr_ptr_r == rd_ptr_r);
    assign level_o   = wr_ptr_r - rd_ptr_r;
    assign rdata_o   = mem_r[rd_ptr_r[PtrW-1:0]];

    // Full/empty are judged on the state before this cycle
    assign push_ok_s = push_i && !full_o;
    assign pop_ok_s  = pop_i && !empty_o;

    // Advance pointers on accepted push/pop; wrap is natural modulo 2*Depth
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_r <= {(PtrW+1){1'b0}};
            rd_ptr_r <= {(PtrW+1){1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PtrOne;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PtrOne;
            end
        end
    end

    // Storage array, cleared on reset so the head never shows stale data
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < Depth; i++) begin
                mem_r[i] <= {Width{1'b0}};
            end
        end else if (push_ok_s) begin
            mem_r[wr_ptr_r[PtrW-1:0]] <= wdata_i;
        end
    end

endmodule

// File: rtl/uart_tx_dev.sv
// Memory-mapped 8N1 UART transmitter: bus register file, TX FIFO,
// serialiser FSM with per-frame latched baud divider, and idle interrupt.
module uart_tx_dev
    import uart_tx_pkg::*;
#(
    parameter int unsigned DataWidth    = 32,
    parameter int unsigned AddressWidth = 32,
    parameter int unsigned FifoDepth    = 8,
    parameter logic [15:0] DefaultDiv   = 16'd15
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    uart_req_i,
    input  logic                    uart_we_i,
    input  logic [3:0]              uart_be_i,
    input  logic [AddressWidth-1:0] uart_addr_i,
    input  logic [DataWidth-1:0]    uart_wdata_i,
    output logic                    uart_rvalid_o,
    output logic [DataWidth-1:0]    uart_rdata_o,
    output logic                    uart_err_o,
    output logic                    tx_o,
    output logic                    uart_irq_o
);

    localparam int unsigned LevelW = $clog2(FifoDepth) + 1;

    // Configuration and bus response
    logic [15:0]          div_r;
    logic                 irq_en_r;
    logic [15:0]          div_next_s;
    logic                 irq_en_next_s;
    logic                 rvalid_r;
    logic [DataWidth-1:0] rdata_r;
    logic                 err_r;
    logic [DataWidth-1:0] rdata_s;
    logic                 err_s;
    logic [DataWidth-1:0] status_s;
    logic [9:0]           reg_addr_s;

    // FIFO interface
    logic                 push_s;
    logic                 pop_s;
    logic [7:0]           fifo_rdata_s;
    logic                 fifo_full_s;
    logic                 fifo_empty_s;
    logic [LevelW-1:0]    fifo_level_s;
    logic [LevelW-1:0]    level_next_s;

    // Serialiser
    uart_tx_state_e       state_r;
    uart_tx_state_e       state_s;
    logic [15:0]          baud_r;
    logic [15:0]          baud_s;
    logic [15:0]          div_lat_r;
    logic [15:0]          div_lat_s;
    logic [2:0]           bit_idx_r;
    logic [2:0]           bit_idx_s;
    logic [7:0]           shift_r;
    logic [7:0]           shift_s;
    logic                 tx_r;
    logic                 tx_s;
    logic                 irq_r;
    logic                 irq_s;

    logic                 unused_s;
    assign unused_s = ^{uart_addr_i[AddressWidth-1:10], uart_addr_i[1:0],
                        uart_wdata_i[DataWidth-1:16], uart_be_i[3:2]};

    assign reg_addr_s = {uart_addr_i[9:2], 2'b00};

    uart_tx_fifo #(
        .Width (8),
        .Depth (FifoDepth)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push_s),
        .wdata_i (uart_wdata_i[7:0]),
        .pop_i   (pop_s),
        .rdata_o (fifo_rdata_s),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s),
        .level_o (fifo_level_s)
    );

    // STATUS word built from pre-cycle state
    always_comb begin
        status_s                                  = {DataWidth{1'b0}};
        status_s[STATUS_FULL_BIT]                 = fifo_full_s;
        status_s[STATUS_EMPTY_BIT]                = fifo_empty_s;
        status_s[STATUS_BUSY_BIT]                 = (state_r != TX_IDLE);
        status_s[STATUS_LEVEL_LSB +: LevelW]      = fifo_level_s;
    end

    // Register decode: read mux, write side effects and error response
    always_comb begin
        rdata_s       = {DataWidth{1'b0}};
        err_s         = 1'b0;
        push_s        = 1'b0;
        div_next_s    = div_r;
        irq_en_next_s = irq_en_r;
        if (uart_req_i) begin
            case (reg_addr_s)
                UART_TXDATA: begin
                    if (uart_we_i && uart_be_i[0]) begin
                        if (fifo_full_s) begin
                            err_s = 1'b1;
                        end else begin
                            push_s = 1'b1;
                        end
                    end else begin
                        push_s = 1'b0;
                    end
                end
                UART_STATUS: begin
                    if (!uart_we_i) begin
                        rdata_s = status_s;
                    end else begin
                        rdata_s = {DataWidth{1'b0}};
                    end
                end
                UART_DIV: begin
                    if (uart_we_i) begin
                        if (uart_be_i[0]) begin
                            div_next_s[7:0] = uart_wdata_i[7:0];
                        end else begin
                            div_next_s[7:0] = div_r[7:0];
                        end
                        if (uart_be_i[1]) begin
                            div_next_s[15:8] = uart_wdata_i[15:8];
                        end else begin
                            div_next_s[15:8] = div_r[15:8];
                        end
                    end else begin
                        rdata_s = DataWidth'(div_r);
                    end
                end
                UART_CTRL: begin
                    if (uart_we_i) begin
                        if (uart_be_i[0]) begin
                            irq_en_next_s = uart_wdata_i[0];
                        end else begin
                            irq_en_next_s = irq_en_r;
                        end
                    end else begin
                        rdata_s = DataWidth'(irq_en_r);
                    end
                end
                default: begin
                    err_s = 1'b1;
                end
            endcase
        end else begin
            err_s = 1'b0;
        end
    end

    // Serialiser next state: start bit, 8 data bits LSB first, stop bit
    always_comb begin
        state_s   = state_r;
        baud_s    = baud_r;
        div_lat_s = div_lat_r;
        bit_idx_s = bit_idx_r;
        shift_s   = shift_r;
        tx_s      = tx_r;
        pop_s     = 1'b0;
        case (state_r)
            TX_IDLE: begin
                if (!fifo_empty_s) begin
                    pop_s     = 1'b1;
                    shift_s   = fifo_rdata_s;
                    baud_s    = div_r;
                    div_lat_s = div_r;
                    bit_idx_s = 3'd0;
                    tx_s      = 1'b0;
                    state_s   = TX_START;
                end else begin
                    tx_s      = 1'b1;
                end
            end
            TX_START: begin
                if (baud_r == 16'd0) begin
                    baud_s    = div_lat_r;
                    bit_idx_s = 3'd0;
                    tx_s      = shift_r[0];
                    state_s   = TX_DATA;
                end else begin
                    baud_s    = baud_r - 16'd1;
                end
            end
            TX_DATA: begin
                if (baud_r == 16'd0) begin
                    baud_s = div_lat_r;
                    if (bit_idx_r == 3'd7) begin
                        tx_s    = 1'b1;
                        state_s = TX_STOP;
                    end else begin
                        bit_idx_s = bit_idx_r + 3'd1;
                        shift_s   = {1'b0, shift_r[7:1]};
                        tx_s      = shift_r[1];
                    end
                end else begin
                    baud_s = baud_r - 16'd1;
                end
            end
            TX_STOP: begin
                if (baud_r == 16'd0) begin
                    tx_s    = 1'b1;
                    state_s = TX_IDLE;
                end else begin
                    baud_s  = baud_r - 16'd1;
                end
            end
            default: begin
                tx_s    = 1'b1;
                state_s = TX_IDLE;
            end
        endcase
    end

    // Interrupt computed from next-cycle state so the registered output
    // tracks irq_en & empty & idle with no extra delay
    always_comb begin
        level_next_s = fifo_level_s + LevelW'(push_s) - LevelW'(pop_s);
        irq_s        = irq_en_next_s && (level_next_s == {LevelW{1'b0}}) &&
                       (state_s == TX_IDLE);
    end

    // Bus response: one cycle after every request, zeroed when not valid
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rvalid_r <= 1'b0;
            rdata_r  <= {DataWidth{1'b0}};
            err_r    <= 1'b0;
        end else begin
            rvalid_r <= uart_req_i;
            rdata_r  <= rdata_s;
            err_r    <= err_s;
        end
    end

    // Configuration registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            div_r    <= DefaultDiv;
            irq_en_r <= 1'b0;
        end else begin
            div_r    <= div_next_s;
            irq_en_r <= irq_en_next_s;
        end
    end

    // Serialiser state, baud counter, shift register, line and interrupt
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r   <= TX_IDLE;
            baud_r    <= 16'd0;
            div_lat_r <= 16'd0;
            bit_idx_r <= 3'd0;
            shift_r   <= 8'd0;
            tx_r      <= 1'b1;
            irq_r     <= 1'b0;
        end else begin
            state_r   <= state_s;
            baud_r    <= baud_s;
            div_lat_r <= div_lat_s;
            bit_idx_r <= bit_idx_s;
            shift_r   <= shift_s;
            tx_r      <= tx_s;
            irq_r     <= irq_s;
        end
    end

    assign uart_rvalid_o = rvalid_r;
    assign uart_rdata_o  = rdata_r;
    assign uart_err_o    = err_r;
    assign tx_o          = tx_r;
    assign uart_irq_o    = irq_r;

endmodule

// File: tb/tb_uart_tx_dev.sv
// Scoreboard bench for uart_tx_dev: bus responses and serial frames are
// predicted at stimulus time and checked by independent monitors.
module tb_uart_tx_dev;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [3:0]  be = 4'h0;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;
    logic        tx;
    logic        irq;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        string       name;
    } resp_t;

    resp_t      resp_q[$];
    logic [7:0] tx_q[$];
    resp_t      mon_r;
    int         mon_div = 15;
    bit         mon_ignore = 1'b0;

    always #5 clk = ~clk;

    uart_tx_dev dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .uart_req_i    (req),
        .uart_we_i     (we),
        .uart_be_i     (be),
        .uart_addr_i   (addr),
        .uart_wdata_i  (wdata),
        .uart_rvalid_o (rvalid),
        .uart_rdata_o  (rdata),
        .uart_err_o    (err),
        .tx_o          (tx),
        .uart_irq_o    (irq)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // One bus access, called at a negedge; returns at the next negedge
    task automatic bus_op(input string name, input logic w, input logic [31:0] a,
                          input logic [3:0] b, input logic [31:0] d,
                          input logic [31:0] exp_rdata, input logic exp_err);
        resp_t r;
        r.rdata = exp_rdata;
        r.err   = exp_err;
        r.name  = name;
        resp_q.push_back(r);
        req = 1'b1; we = w; addr = a; be = b; wdata = d;
        @(negedge clk);
        req = 1'b0; we = 1'b0; addr = 32'h0; be = 4'h0; wdata = 32'h0;
    endtask

    task automatic tx_write(input string name, input logic [7:0] b, input logic exp_err);
        bus_op(name, 1'b1, 32'h0, 4'b0001, {24'h0, b}, 32'h0, exp_err);
        if (!exp_err) tx_q.push_back(b);
    endtask

    // Expected line level j cycles after the write, for a frame starting at sj
    function automatic logic exp_frame(input int j, input int sj, input int d, input logic [7:0] b);
        int s;
        if (j < sj) return 1'b1;
        s = (j - sj) / d;
        if (s == 0) return 1'b0;
        if (s <= 8) return b[s-1];
        return 1'b1;
    endfunction

    // Response monitor: pops a prediction whenever rvalid is seen
    always @(negedge clk) begin
        if (rst_n) begin
            if (rvalid) begin
                if (resp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_rvalid: got rdata 0x%08h err %0b, expected no response", rdata, err);
                end else begin
                    mon_r = resp_q.pop_front();
                    check({mon_r.name, "_rdata"}, rdata, mon_r.rdata);
                    check({mon_r.name, "_err"}, {31'd0, err}, {31'd0, mon_r.err});
                end
            end else begin
                check("idle_resp_zero", rdata | {31'd0, err}, 32'h0);
            end
        end
    end

    // Serial monitor: decodes 8N1 frames at mid-bit and checks byte order
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && tx === 1'b0) begin
                int         d;
                bit         ign;
                logic       sb;
                logic       stp;
                logic [7:0] b;
                d   = mon_div + 1;
                ign = mon_ignore;
                repeat (d / 2) @(negedge clk);
                sb = tx;
                for (int i = 0; i < 8; i++) begin
                    repeat (d) @(negedge clk);
                    b[i] = tx;
                end
                repeat (d) @(negedge clk);
                stp = tx;
                if (!ign) begin
                    check("start_bit", {31'd0, sb}, 32'h0);
                    check("stop_bit", {31'd0, stp}, 32'h1);
                    if (tx_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL unexpected_frame: got byte 0x%02h, expected no frame", b);
                    end else begin
                        check("tx_byte", {24'h0, b}, {24'h0, tx_q.pop_front()});
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, expected end of run");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_tx", {31'd0, tx}, 32'h1);
        check("rst_irq", {31'd0, irq}, 32'h0);
        check("rst_rvalid", {31'd0, rvalid}, 32'h0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_err", {31'd0, err}, 32'h0);
        rst_n = 1'b1;
        bus_op("stat_after_rst", 1'b0, 32'h4, 4'hF, 32'h0, 32'h0000_0002, 1'b0);
        bus_op("div_default", 1'b0, 32'h8, 4'hF, 32'h0, 32'h0000_000F, 1'b0);

        // DIV=1, single 0xA5 frame: exact waveform
        bus_op("div1_wr", 1'b1, 32'h8, 4'b0011, 32'h1, 32'h0, 1'b0);
        mon_div = 1;
        tx_write("a5_wr", 8'hA5, 1'b0);
        for (int j = 0; j <= 24; j++) begin
            if (j > 0) @(negedge clk);
            check($sformatf("a5_line_%0d", j), {31'd0, tx}, {31'd0, exp_frame(j, 1, 2, 8'hA5)});
        end

        // Interrupt with two back-to-back frames at DIV=3
        bus_op("div3_wr", 1'b1, 32'h8, 4'b0011, 32'h3, 32'h0, 1'b0);
        mon_div = 3;
        bus_op("ctrl_wr", 1'b1, 32'hC, 4'b0001, 32'h1, 32'h0, 1'b0);
        check("irq_idle_en", {31'd0, irq}, 32'h1);
        tx_write("b1_wr", 8'h3C, 1'b0);
        for (int j = 0; j <= 90; j++) begin
            if (j == 1) tx_write("b2_wr", 8'h81, 1'b0);
            else if (j > 1) @(negedge clk);
            check($sformatf("irq_line_%0d", j), {31'd0, tx},
                  {31'd0, (j < 42) ? exp_frame(j, 1, 4, 8'h3C) : exp_frame(j, 42, 4, 8'h81)});
            check($sformatf("irq_lvl_%0d", j), {31'd0, irq}, {31'd0, (j >= 82)});
        end

        // Error responses, ignored writes, byte enables
        bus_op("bad_rd", 1'b0, 32'h10, 4'hF, 32'h0, 32'h0, 1'b1);
        bus_op("bad_wr", 1'b1, 32'h10, 4'hF, 32'hFFFF_FFFF, 32'h0, 1'b1);
        bus_op("div_keep", 1'b0, 32'h8, 4'hF, 32'h0, 32'h0000_0003, 1'b0);
        bus_op("ctrl_keep", 1'b0, 32'hC, 4'hF, 32'h0, 32'h0000_0001, 1'b0);
        bus_op("txd_no_be0", 1'b1, 32'h0, 4'b1110, 32'h0000_00EE, 32'h0, 1'b0);
        bus_op("txd_rd", 1'b0, 32'h0, 4'hF, 32'h0, 32'h0, 1'b0);
        bus_op("stat_wr", 1'b1, 32'h4, 4'hF, 32'hFFFF_FFFF, 32'h0, 1'b0);
        bus_op("stat_idle", 1'b0, 32'h4, 4'hF, 32'h0, 32'h0000_0002, 1'b0);
        bus_op("div_be1_wr", 1'b1, 32'h8, 4'b0010, 32'h1234_5678, 32'h0, 1'b0);
        bus_op("div_be1_rd", 1'b0, 32'h8, 4'hF, 32'h0, 32'h0000_5603, 1'b0);
        for (int j = 0; j < 30; j++) begin
            @(negedge clk);
            check("no_tx_line", {31'd0, tx}, 32'h1);
        end

        // FIFO overflow: 10 back-to-back writes, 9 fit thanks to the first pop
        bus_op("div_ff_wr", 1'b1, 32'h8, 4'b0011, 32'h0000_00FF, 32'h0, 1'b0);
        mon_div = 255;
        for (int i = 0; i < 10; i++) begin
            tx_write($sformatf("fill_%0d", i), 8'h10 + 8'(i), (i == 9));
        end
        bus_op("stat_full", 1'b0, 32'h4, 4'hF, 32'h0, 32'h0000_0405, 1'b0);
        repeat (23100) @(negedge clk);
        bus_op("stat_drained", 1'b0, 32'h4, 4'hF, 32'h0, 32'h0000_0002, 1'b0);

        // Reset in the middle of a data bit
        bus_op("div3b_wr", 1'b1, 32'h8, 4'b0011, 32'h3, 32'h0, 1'b0);
        mon_div    = 3;
        mon_ignore = 1'b1;
        bus_op("abort_wr", 1'b1, 32'h0, 4'b0001, 32'h0, 32'h0, 1'b0);
        repeat (6) @(negedge clk);
        check("mid_bit_line", {31'd0, tx}, 32'h0);
        req = 1'b1; we = 1'b0; addr = 32'h4; be = 4'hF;
        @(posedge clk);
        #1;
        check("pre_rst_rvalid", {31'd0, rvalid}, 32'h1);
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_tx", {31'd0, tx}, 32'h1);
        check("async_rst_rvalid", {31'd0, rvalid}, 32'h0);
        check("async_rst_rdata", rdata, 32'h0);
        @(negedge clk);
        req = 1'b0; addr = 32'h0; be = 4'h0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (50) @(negedge clk);
        mon_ignore = 1'b0;
        bus_op("stat_post_rst", 1'b0, 32'h4, 4'hF, 32'h0, 32'h0000_0002, 1'b0);
        bus_op("div_post_rst", 1'b0, 32'h8, 4'hF, 32'h0, 32'h0000_000F, 1'b0);
        bus_op("ctrl_post_rst", 1'b0, 32'hC, 4'hF, 32'h0, 32'h0, 1'b0);
        check("irq_post_rst", {31'd0, irq}, 32'h0);

        repeat (20) @(negedge clk);
        check("resp_q_drained", 32'(resp_q.size()), 32'h0);
        check("tx_q_drained", 32'(tx_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
